nibble_pack_arbiter: RTL and testbench
======================================

NIBBLE_PACK_ARBITER -- requirements
Module: nibble_pack_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of nibble-stream requesters (2..8).
REQ-002 SHALL have parameter NIB_PER_WORD, default 8, nibbles per packed 32-bit word.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester nibble available.
REQ-006 SHALL have port req_data  input  4*NUM_REQ  per-requester nibble; requester i occupies bits [4i+3:4i].
REQ-007 SHALL have port req_last  input  NUM_REQ  qualifies req_data as the final nibble of requester's stream.
REQ-008 SHALL have port req_ready  output  NUM_REQ  nibble accepted from requester i when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port pk_data  output  4  nibble to packer.
REQ-010 SHALL have port pk_valid  output  1  packer input strobe; exactly one nibble per high cycle.
REQ-011 SHALL have port word_done  output  1  one-cycle pulse: a full word's nibbles have been issued.
REQ-012 SHALL have port word_owner  output  $clog2(NUM_REQ)  requester index owning the word flagged by word_done; held until the next word_done.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, GRANT, XFER, PAD.
REQ-015 IDLE: if any req_valid high, SHALL select the requester by round-robin starting from pointer rr_ptr, register grant index g, go to GRANT; else stay.
REQ-016 GRANT: one-cycle bubble; SHALL clear nibble counter cnt to 0 and go to XFER.
REQ-017 XFER: req_ready[g] SHALL be 1 and all other req_ready 0; pk_valid = req_valid[g]; pk_data = nibble of g (combinational pass-through).
REQ-018 XFER: each accepted nibble SHALL increment cnt (width $clog2(NIB_PER_WORD)).
REQ-019 XFER: acceptance with cnt == NIB_PER_WORD-1 SHALL complete the word: go to IDLE, rr_ptr <= (g+1) mod NUM_REQ, regardless of req_last.
REQ-020 XFER: acceptance with req_last high and cnt < NIB_PER_WORD-1 SHALL go to PAD.
REQ-021 PAD: req_ready all 0; pk_valid = 1, pk_data = 4'h0 each cycle, cnt incrementing, until the nibble at cnt == NIB_PER_WORD-1 is issued; then go to IDLE with rr_ptr update as REQ-019.
REQ-022 word_done SHALL pulse, registered, in the cycle after the last nibble of a word (data or pad) is issued; word_owner updated to g in the same cycle.
REQ-023 Words SHALL never interleave requesters: grant held from first to last nibble; req_valid[g] low stalls without timeout.
REQ-024 Round-robin SHALL search rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ; a single active requester is regranted after each word.
REQ-025 pk_valid SHALL be 0 in IDLE and GRANT; count of pk_valid cycles between word_done pulses SHALL equal NIB_PER_WORD.
REQ-026 Minimum throughput: NIB_PER_WORD+2 cycles per word (IDLE, GRANT, NIB_PER_WORD transfers).

Reset
REQ-027 On reset: state IDLE, g 0, rr_ptr 0, cnt 0, word_done 0, word_owner 0, busy 0, req_ready 0, pk_valid 0, pk_data 0.
REQ-028 Reset mid-word SHALL discard the partial word without padding; the packer SHALL share the same reset so word alignment restarts at nibble 0.

Structure
REQ-029 Shared package SHALL hold the state enum encoding (IDLE=0, GRANT=1, XFER=2, PAD=3) and NIB_PER_WORD default constant.
REQ-030 One sub-module rr_arbiter (request vector + pointer -> one-hot grant and index, combinational) SHALL be instantiated; the rest stays in the top.

Verification
REQ-031 Single requester 0, 8 nibbles 1..8 back-to-back -> pk_data 1..8 on 8 consecutive pk_valid cycles, word_done one cycle later, word_owner 0, packer output 32'h12345678.
REQ-032 Requesters 0 and 2 continuously valid, 3 words -> owners 0, 2, 0; no req_ready to a non-granted requester.
REQ-033 Requester 1 sends 3 nibbles A,B,C with req_last on C -> pk_data A,B,C,0,0,0,0,0; word_owner 1; packer output 32'hABC00000.
REQ-034 Granted requester drops req_valid for 5 cycles after nibble 4 -> pk_valid low 5 cycles, grant retained, word completes correctly, no other requester served.
REQ-035 Assert reset after nibble 5 of a word -> all outputs at reset values next cycle; next word starts at cnt 0 with rr_ptr 0.

Source files
------------

// File: rtl/nibble_pack_arbiter_pkg.sv
// Shared definitions for the nibble pack arbiter: FSM state encoding,
// default word geometry and a small index helper.
package nibble_pack_arbiter_pkg;

  // Nibbles in one packed 32-bit word unless overridden.
  localparam int NIB_PER_WORD_DEF = 8;

  // FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_GRANT = 2'd1;
  localparam state_t ST_XFER  = 2'd2;
  localparam state_t ST_PAD   = 2'd3;

  // Modulo-n increment of a requester index, used to compute the next
  // round-robin search start.
  function automatic int wrap_inc(input int idx, input int n);
    int nxt;
    nxt = idx + 1;
    if (nxt >= n) begin
      nxt = 0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/nibble_pack_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches the request vector starting at
// ptr and wrapping, returning the first active requester as one-hot and index.
module rr_arbiter
  import nibble_pack_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx
);

  // First requester found at ptr, ptr+1, ... (mod N) wins.
  always_comb begin
    int  cand_s;
    logic found_s;
    grant_oh  = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    cand_s    = 0;
    for (int k = 0; k < N; k++) begin
      cand_s = int'(ptr) + k;
      if (cand_s >= N) begin
        cand_s = cand_s - N;
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s]) begin
        found_s          = 1'b1;
        grant_oh[cand_s] = 1'b1;
        grant_idx        = IW'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/nibble_pack_arbiter.sv
// Nibble pack arbiter: grants one requester at a time for a whole packed
// word, forwards its nibbles to the packer, pads short streams with zero
// nibbles and reports which requester owned each completed word.
module nibble_pack_arbiter
  import nibble_pack_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int NIB_PER_WORD = NIB_PER_WORD_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [4*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [3:0]                 pk_data,
  output logic                       pk_valid,
  output logic                       word_done,
  output logic [$clog2(NUM_REQ)-1:0] word_owner,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(NIB_PER_WORD);
  localparam logic [CW-1:0] CNT_LAST = CW'(NIB_PER_WORD - 1);

  state_t            state_r;
  logic [IW-1:0]     g_r;
  logic [IW-1:0]     rr_ptr_r;
  logic [CW-1:0]     cnt_r;
  logic              word_done_r;
  logic [IW-1:0]     word_owner_r;

  logic [NUM_REQ-1:0] arb_oh_s;
  logic [IW-1:0]      arb_idx_s;
  logic               arb_any_s;
  logic               g_valid_s;
  logic               g_last_s;
  logic [3:0]         g_data_s;
  logic               word_last_s;
  logic [IW-1:0]      ptr_next_s;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant_oh  (arb_oh_s),
    .grant_idx (arb_idx_s)
  );

  assign arb_any_s   = |arb_oh_s;
  assign g_valid_s   = req_valid[g_r];
  assign g_last_s    = req_last[g_r];
  assign g_data_s    = req_data[{g_r, 2'b00} +: 4];
  assign word_last_s = (cnt_r == CNT_LAST);
  assign ptr_next_s  = IW'(wrap_inc(int'(g_r), NUM_REQ));

  // Datapath steering: only the granted requester sees ready; pad issues zeros.
  always_comb begin
    req_ready = '0;
    pk_valid  = 1'b0;
    pk_data   = 4'h0;
    case (state_r)
      ST_XFER: begin
        req_ready[g_r] = 1'b1;
        pk_valid       = g_valid_s;
        pk_data        = g_data_s;
      end
      ST_PAD: begin
        pk_valid = 1'b1;
        pk_data  = 4'h0;
      end
      default: begin
        pk_valid = 1'b0;
      end
    endcase
  end

  // Word-level FSM: arbitrate, bubble, transfer, pad, then release the grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      g_r          <= '0;
      rr_ptr_r     <= '0;
      cnt_r        <= '0;
      word_done_r  <= 1'b0;
      word_owner_r <= '0;
    end else begin
      word_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (arb_any_s) begin
            g_r     <= arb_idx_s;
            state_r <= ST_GRANT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          cnt_r   <= '0;
          state_r <= ST_XFER;
        end
        ST_XFER: begin
          if (g_valid_s) begin
            cnt_r <= cnt_r + CW'(1);
            if (word_last_s) begin
              state_r      <= ST_IDLE;
              rr_ptr_r     <= ptr_next_s;
              word_done_r  <= 1'b1;
              word_owner_r <= g_r;
            end else if (g_last_s) begin
              state_r <= ST_PAD;
            end else begin
              state_r <= ST_XFER;
            end
          end else begin
            state_r <= ST_XFER;
          end
        end
        ST_PAD: begin
          cnt_r <= cnt_r + CW'(1);
          if (word_last_s) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= ptr_next_s;
            word_done_r  <= 1'b1;
            word_owner_r <= g_r;
          end else begin
            state_r <= ST_PAD;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign word_done  = word_done_r;
  assign word_owner = word_owner_r;
  assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_nibble_pack_arbiter.sv
// Scoreboard bench for nibble_pack_arbiter: requester streams are turned
// into expected packed words at generation time; a monitor reassembles the
// packer stream, predicts round-robin owners and compares on word_done.
module tb_nibble_pack_arbiter;

  localparam int N   = 4;
  localparam int NPW = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [3:0]     pk_data;
  logic           pk_valid;
  logic           word_done;
  logic [1:0]     word_owner;
  logic           busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nibble_pack_arbiter #(.NUM_REQ(N), .NIB_PER_WORD(NPW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .pk_data    (pk_data),
    .pk_valid   (pk_valid),
    .word_done  (word_done),
    .word_owner (word_owner),
    .busy       (busy)
  );

  // Stimulus-side state: pending nibbles ({last, data}) and expected words.
  logic [4:0]  nib_q     [N][$];
  logic [31:0] exp_words [N][$];
  logic [3:0]  tmp_q     [$];
  int          acc_cnt   [N];
  int          stall_cnt = 0;
  int          stall_r   = 0;
  int          stall_arm = 0;

  // Monitor-side model state.
  int          own_q[$];
  int          idle_m    = 1;
  int          rr_m      = 0;
  int          cur_owner = -1;
  int          lat_exp   = -1;
  int          cyc       = 0;
  int          dec_cyc   = -10;
  int          first_cyc = 0;
  int          asm_n     = 0;
  logic [31:0] asm_w     = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) begin
      if (nib_q[i].size() > 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Move tmp_q into requester r's stream and derive its expected packed words.
  task automatic commit(input int r);
    logic [31:0] w;
    int n;
    int sz;
    w  = 32'h0;
    n  = 0;
    sz = tmp_q.size();
    for (int k = 0; k < sz; k++) begin
      nib_q[r].push_back({(k == sz - 1), tmp_q[k]});
      w = {w[27:0], tmp_q[k]};
      n++;
      if (n == NPW) begin
        exp_words[r].push_back(w);
        w = 32'h0;
        n = 0;
      end
    end
    if (n > 0) begin
      w = w << (4 * (NPW - n));
      exp_words[r].push_back(w);
    end
    tmp_q.delete();
  endtask

  task automatic rand_stream(input int r, input int len);
    for (int k = 0; k < len; k++) tmp_q.push_back(4'($urandom_range(15)));
    commit(r);
  endtask

  task automatic drive(input int prob);
    for (int i = 0; i < N; i++) begin
      logic       on;
      logic [4:0] h;
      on = (nib_q[i].size() > 0) && ($urandom_range(99) < prob);
      if (stall_cnt > 0 && i == stall_r) on = 1'b0;
      req_valid[i] = on;
      if (on) begin
        h = nib_q[i][0];
        req_data[4*i +: 4] = h[3:0];
        req_last[i]        = h[4];
      end else begin
        req_data[4*i +: 4] = 4'($urandom_range(15));
        req_last[i]        = 1'($urandom_range(1));
      end
    end
    if (stall_cnt > 0) stall_cnt--;
  endtask

  // Run until all streams are consumed and the last word reported, or until
  // requester stop_r has had stop_n nibbles accepted.
  task automatic run_phase(input int prob, input int budget, input int stop_r, input int stop_n);
    int n;
    logic [N-1:0] acc;
    logic [4:0] h;
    n = 0;
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    drive(prob);
    while ((pending() || idle_m == 0) && n < budget) begin
      if (stop_r >= 0 && acc_cnt[stop_r] >= stop_n) break;
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          h = nib_q[i].pop_front();
          acc_cnt[i]++;
          if (stall_arm != 0 && i == stall_r && acc_cnt[i] == 4) begin
            stall_cnt = 5;
            stall_arm = 0;
          end
        end
      end
      drive(prob);
      n++;
    end
    if (n >= budget) check("phase_timeout", 32'(n), 32'(budget - 1));
    if (stop_r < 0) begin
      for (int i = 0; i < N; i++) check($sformatf("words_left_%0d", i), 32'(exp_words[i].size()), 32'h0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      nib_q[i].delete();
      exp_words[i].delete();
      acc_cnt[i] = 0;
    end
    stall_cnt = 0;
    stall_arm = 0;
    req_valid = '1;
    req_data  = 16'($urandom);
    req_last  = '1;
    @(negedge clk);
    check("rst_pk_valid", 32'(pk_valid), 32'h0);
    check("rst_pk_data", 32'(pk_data), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_word_done", 32'(word_done), 32'h0);
    check("rst_word_owner", 32'(word_owner), 32'h0);
    req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: reassemble packer words, predict owners, compare on word_done.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        own_q.delete();
        idle_m    = 1;
        rr_m      = 0;
        cur_owner = -1;
        asm_n     = 0;
        asm_w     = 32'h0;
        dec_cyc   = -10;
      end else begin
        if (word_done) begin
          if (own_q.size() == 0) begin
            check("spurious_word_done", 32'(word_done), 32'h0);
          end else begin
            int eo;
            eo = own_q.pop_front();
            check("word_owner", 32'(word_owner), 32'(eo));
            check("nibbles_per_word", 32'(asm_n), 32'(NPW));
            if (exp_words[eo].size() == 0) check("word_data_unexpected", asm_w, 32'hFFFF_FFFF ^ asm_w);
            else check("word_data", asm_w, exp_words[eo].pop_front());
            if (lat_exp >= 0) begin
              check("first_nibble_latency", 32'(first_cyc - dec_cyc), 32'd2);
              check("word_span", 32'(cyc - first_cyc), 32'(lat_exp));
              lat_exp = -1;
            end
            rr_m      = (eo + 1) % N;
            idle_m    = 1;
            cur_owner = -1;
            asm_n     = 0;
            asm_w     = 32'h0;
          end
        end
        if (cyc == dec_cyc + 1) begin
          check("grant_bubble_pk_valid", 32'(pk_valid), 32'h0);
          check("grant_bubble_ready", 32'(req_ready), 32'h0);
        end
        if (|req_ready) begin
          if (cur_owner < 0) check("ready_while_idle", 32'(req_ready), 32'h0);
          else check("ready_exclusive", 32'(req_ready & ~(4'b0001 << cur_owner)), 32'h0);
        end
        check("busy", 32'(busy), (idle_m != 0) ? 32'h0 : 32'h1);
        if (pk_valid) begin
          if (idle_m != 0) begin
            check("pk_valid_idle", 32'(pk_valid), 32'h0);
          end else begin
            if (asm_n == 0) first_cyc = cyc;
            asm_w = {asm_w[27:0], pk_data};
            asm_n++;
          end
        end
        if (idle_m != 0 && |req_valid) begin
          cur_owner = rr_pick(req_valid, rr_m);
          own_q.push_back(cur_owner);
          idle_m  = 0;
          dec_cyc = cyc;
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    do_reset();

    // Single requester, nibbles 1..8 back-to-back -> 32'h12345678.
    lat_exp = 8;
    for (int v = 1; v <= 8; v++) tmp_q.push_back(4'(v));
    commit(0);
    run_phase(100, 200, -1, 0);

    // Requesters 0 and 2 continuously valid from reset -> owners 0, 2, 0.
    do_reset();
    rand_stream(0, 16);
    rand_stream(2, 8);
    run_phase(100, 300, -1, 0);

    // Short stream A,B,C with last -> 32'hABC00000 from requester 1.
    tmp_q.push_back(4'hA);
    tmp_q.push_back(4'hB);
    tmp_q.push_back(4'hC);
    commit(1);
    run_phase(100, 200, -1, 0);

    // Granted requester stalls 5 cycles after nibble 4; requester 1 waits.
    lat_exp   = 13;
    stall_r   = 0;
    stall_arm = 1;
    rand_stream(0, 8);
    rand_stream(1, 8);
    run_phase(100, 300, -1, 0);

    // Reset after nibble 5; the next word must start from a clean state.
    rand_stream(0, 16);
    rand_stream(1, 8);
    run_phase(100, 300, 0, 5);
    do_reset();
    rand_stream(1, 8);
    rand_stream(0, 8);
    run_phase(100, 300, -1, 0);

    // Randomized traffic with random stalls.
    for (int it = 0; it < 25; it++) begin
      int ns;
      ns = $urandom_range(1, 4);
      for (int s = 0; s < ns; s++) rand_stream($urandom_range(N - 1), $urandom_range(1, 20));
      run_phase($urandom_range(40, 100), 4000, -1, 0);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
